ahb_traffic_gen: RTL

//  Synthesizable AHB-Lite master that sits directly upstream of BridgeTop. It turns

---
 rtl/ahb_traffic_gen_pkg.sv | 20 ++
 rtl/ahb_beat_ctr.sv | 41 ++++
 rtl/ahb_traffic_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ahb_traffic_gen_pkg.sv
// rtl/ahb_traffic_gen_pkg.sv - shared AHB encodings and FSM states for ahb_traffic_gen
// Contents: HTRANS_* / HRESP_* codes, state_t for the master FSM.
package ahb_traffic_gen_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_PIPE = 3'd2,
        ST_LAST = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_beat_ctr.sv
// rtl/ahb_beat_ctr.sv - address/beat counter with load, enable and terminal flag
// Ports: clk, rst_n (async active-low), load + load_addr/load_len, en (advance one beat),
//        addr (current address-phase address), beat (address-phase beat index),
//        last (beat is the final beat of the burst).
module ahb_beat_ctr #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  beat,
    output logic              last
);

    logic [LEN_W-1:0] len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            beat <= '0;
            len  <= '0;
        end else if (load) begin
            addr <= load_addr;
            beat <= '0;
            len  <= load_len;
        end else if (en) begin
            // Address wraps naturally at 2^ADDR_W; no 1KB boundary handling here.
            addr <= addr + ADDR_W'(ADDR_STEP);
            beat <= beat + LEN_W'(1);
        end
    end

    assign last = (beat == len);

endmodule

// File: rtl/ahb_traffic_gen.sv
// rtl/ahb_traffic_gen.sv - AHB-Lite master turning single/INCR commands into pipelined transfers
// Ports: Hclk/Hresetn; command side cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_len;
//        AHB side Hreadyout/Hresp/Hrdata in, Hwrite/Hreadyin/Htrans/Haddr/Hwdata out;
//        response side rsp_valid/rsp_rdata/rsp_err and cmd_done pulses.
module ahb_traffic_gen #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              Hreadyout,
    input  logic [1:0]        Hresp,
    input  logic [DATA_W-1:0] Hrdata,
    output logic              Hwrite,
    output logic              Hreadyin,
    output logic [1:0]        Htrans,
    output logic [ADDR_W-1:0] Haddr,
    output logic [DATA_W-1:0] Hwdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              cmd_done
);

    import ahb_traffic_gen_pkg::*;

    state_t            state;
    logic [DATA_W-1:0] wdata_base;
    logic [LEN_W-1:0]  beat;
    logic              beat_last;
    logic              accept;
    logic              ctr_en;
    logic              bus_err;
    logic [DATA_W-1:0] beat_rdata;
    logic [DATA_W-1:0] next_wdata;

    // Single-slave fabric: HREADY seen by the slave is its own ready.
    assign Hreadyin   = Hreadyout;
    assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign bus_err    = (Hresp == HRESP_ERROR);
    assign beat_rdata = Hwrite ? '0 : Hrdata;
    // beat is the index of the address phase that is completing, which is also
    // the beat whose data phase starts next.
    assign next_wdata = wdata_base + DATA_W'(beat);

    // Advance the address only when another beat remains and the bus moves.
    assign ctr_en = Hreadyout && !beat_last &&
                    ((state == ST_ADDR) || ((state == ST_PIPE) && !bus_err));

    ahb_beat_ctr #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_beat_ctr (
        .clk       (Hclk),
        .rst_n     (Hresetn),
        .load      (accept),
        .en        (ctr_en),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .addr      (Haddr),
        .beat      (beat),
        .last      (beat_last)
    );

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            Htrans     <= HTRANS_IDLE;
            Hwrite     <= 1'b0;
            Hwdata     <= '0;
            wdata_base <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cmd_done   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cmd_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready  <= 1'b0;
                        Hwrite     <= cmd_write;
                        wdata_base <= cmd_wdata;
                        Htrans     <= HTRANS_NONSEQ;
                        state      <= ST_ADDR;
                    end else begin
                        // Entering IDLE with cmd_ready low guarantees one idle
                        // cycle after cmd_done before the next accept.
                        cmd_ready <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (Hreadyout) begin
                        Hwdata <= next_wdata;
                        if (beat_last) begin
                            Htrans <= HTRANS_IDLE;
                            state  <= ST_LAST;
                        end else begin
                            Htrans <= HTRANS_SEQ;
                            state  <= ST_PIPE;
                        end
                    end
                end
                ST_PIPE: begin
                    if (bus_err) begin
                        // Cancel the pending SEQ; remaining beats are dropped.
                        Htrans <= HTRANS_IDLE;
                        if (Hreadyout) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= beat_rdata;
                            cmd_done  <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_ERR;
                        end
                    end else if (Hreadyout) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= beat_rdata;
                        Hwdata    <= next_wdata;
                        if (beat_last) begin
                            Htrans <= HTRANS_IDLE;
                            state  <= ST_LAST;
                        end else begin
                            Htrans <= HTRANS_SEQ;
                        end
                    end
                end
                ST_LAST: begin
                    if (bus_err && !Hreadyout) begin
                        state <= ST_ERR;
                    end else if (Hreadyout) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= bus_err;
                        rsp_rdata <= beat_rdata;
                        cmd_done  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (Hreadyout) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= beat_rdata;
                        cmd_done  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    Htrans <= HTRANS_IDLE;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
